// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared state encodings and default width for the sequential divider
package seq_divider_pkg;

    localparam int DIV_WIDTH = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/seq_divider_div_step.sv
// seq_divider_div_step: one restoring-division iteration using invert-and-add-one subtract
module seq_divider_div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rs_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   r_next_o,
    output logic             q_bit_o
);

    logic [WIDTH+1:0] sum;

    // Carry out of Rs + ~D + 1 means no borrow, i.e. Rs >= D
    always_comb begin
        sum      = {1'b0, rs_i} + {1'b0, ~{1'b0, d_i}} + (WIDTH+2)'(1);
        q_bit_o  = sum[WIDTH+1];
        r_next_o = sum[WIDTH+1] ? sum[WIDTH:0] : rs_i;
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider with start/done handshake
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_zero
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic [WIDTH:0]   rs, r_next;
    logic             q_bit;

    assign rs = (r_q << 1) | {{WIDTH{1'b0}}, acc_q[WIDTH-1]};

    seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
        .rs_i     (rs),
        .d_i      (div_q),
        .r_next_o (r_next),
        .q_bit_o  (q_bit)
    );

    // Next-state: iterate in CALC, accept starts from IDLE or DONE, publish results on DONE entry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        acc_d   = acc_q;
        div_d   = div_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        if (state_q == S_CALC) begin
            r_d   = r_next;
            acc_d = {acc_q[WIDTH-2:0], q_bit};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) begin
                state_d = S_DONE;
                quo_d   = {acc_q[WIDTH-2:0], q_bit};
                rem_d   = r_next[WIDTH-1:0];
                dz_d    = 1'b0;
            end
        end else if (i_start) begin
            div_d = i_divisor;
            if (i_divisor == '0) begin
                state_d = S_DONE;
                quo_d   = '1;
                rem_d   = i_dividend;
                dz_d    = 1'b1;
            end else begin
                state_d = S_CALC;
                cnt_d   = '0;
                r_d     = '0;
                acc_d   = i_dividend;
            end
        end else begin
            state_d = S_IDLE;
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign o_busy      = (state_q == S_CALC);
    assign o_done      = (state_q == S_DONE);
    assign o_quotient  = quo_q;
    assign o_remainder = rem_q;
    assign o_div_zero  = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed scoreboard bench for seq_divider
module tb_seq_divider;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_start;
    logic [W-1:0] i_dividend;
    logic [W-1:0] i_divisor;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_div_zero;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t mon_e;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder),
        .o_div_zero  (o_div_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.q  = (b == 0) ? {W{1'b1}} : a / b;
        e.r  = (b == 0) ? a : a % b;
        e.dz = (b == 0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && o_done) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done got q=%0d r=%0d dz=%0d expected no done", o_quotient, o_remainder, o_div_zero);
            end else begin
                mon_e = sb.pop_front();
                if ({o_quotient, o_remainder, o_div_zero} !== mon_e) begin
                    miscompares++;
                    $display("FAIL result got q=%0d r=%0d dz=%0d expected q=%0d r=%0d dz=%0d",
                             o_quotient, o_remainder, o_div_zero, mon_e.q, mon_e.r, mon_e.dz);
                end
            end
        end
    end

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int idle);
        int n;
        int nb;
        i_dividend = a;
        i_divisor  = b;
        i_start    = 1'b1;
        sb.push_back(model(a, b));
        n  = 0;
        nb = 0;
        do begin
            @(posedge clk);
            #1;
            i_start = 1'b0;
            n++;
            nb += int'(o_busy);
        end while (!o_done && n < 20);
        chk("latency", n, (b == 0) ? 1 : W + 1);
        chk("busy_cycles", nb, (b == 0) ? 0 : W);
        repeat (idle) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_q"}, o_quotient, 0);
        chk({tag, "_r"}, o_remainder, 0);
        chk({tag, "_dz"}, o_div_zero, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        i_start    = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        #12;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(4'd13, 4'd4, 1);
        run(4'd15, 4'd1, 1);
        run(4'd3, 4'd9, 1);
        run(4'd0, 4'd5, 1);
        run(4'd7, 4'd0, 1);
        sb.push_back(model(4'd12, 4'd5));
        i_dividend = 4'd12;
        i_divisor  = 4'd5;
        i_start    = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        @(posedge clk);
        #1;
        i_dividend = 4'd9;
        i_divisor  = 4'd3;
        i_start    = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        chk("busy_mid_calc", o_busy, 1);
        chk("held_q_mid_calc", o_quotient, 15);
        chk("held_r_mid_calc", o_remainder, 7);
        n = 0;
        while (!o_done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ignored_start_done", o_done, 1);
        run(4'd9, 4'd3, 2);
        i_dividend = 4'd14;
        i_divisor  = 4'd3;
        i_start    = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("async_reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        run(4'd14, 4'd3, 1);
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run(4'(a), 4'(b), a % 2);
        repeat (60) run(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential unsigned restoring divider for the ALU exercise datapath. It computes quotient and remainder by shift-and-subtract, one quotient bit per clock. It uses the same carry/borrow subtract formulation as the combinational adder/subtractor. It sits beside the ALU as a multi-cycle execution unit with a start/done handshake.

Parameters:
- WIDTH, 4, operand, quotient and remainder width in bits (minimum 2).

Ports:
- clk, input, 1, rising-edge clock
- rst_n, input, 1, asynchronous active-low reset
- i_start, input, 1, request a division; sampled only when o_busy=0
- i_dividend, input, WIDTH, dividend; captured on accepted start
- i_divisor, input, WIDTH, divisor; captured on accepted start
- o_busy, output, 1, high while iterating (state CALC)
- o_done, output, 1, one-cycle pulse when results become valid
- o_quotient, output, WIDTH, quotient; held until the next accepted start
- o_remainder, output, WIDTH, remainder; held until the next accepted start
- o_div_zero, output, 1, divisor was zero; valid with o_done and held like the results

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE
  - o_busy=0, o_done=0, o_div_zero=0
  - o_quotient=0, o_remainder=0
  - internal counter and registers cleared.
- States and transitions:
  - IDLE: on i_start=1, capture operands. If the divisor is 0, go to DONE. Otherwise go to CALC with count=0, R={WIDTH+1{0}}, Q=dividend.
  - CALC: perform one iteration per clock. After iteration WIDTH-1 (count==WIDTH-1), go to DONE.
  - DONE: o_done=1 for this single cycle; outputs are updated in the same edge that enters DONE. Next state is IDLE, unless i_start=1, which is accepted exactly as in IDLE (back-to-back operation).
- Iteration (all widths WIDTH+1, no truncation):
  - Rs = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - Compute diff = Rs + ~{1'b0,D} + 1; borrow = ~carry_out.
  - If borrow=0: R=diff and Q={Q[WIDTH-2:0],1}. Otherwise R=Rs and Q={Q[WIDTH-2:0],0}.
- Latency:
  - Nonzero divisor: o_done is high in the cycle following the WIDTH-th edge after the start-sampling edge (start at edge k, o_done high after edge k+WIDTH+1). For WIDTH=4 that is 5 edges.
  - Zero divisor: o_done is high after edge k+1.
- Divide by zero: o_quotient = all ones, o_remainder = dividend, o_div_zero=1. No CALC cycles occur.
- o_div_zero is 0 for every nonzero-divisor result.
- i_start while o_busy=1 is ignored. Operand changes during CALC have no effect.
- Dividend < divisor gives quotient 0, remainder = dividend. Dividend = 0 gives 0/0 results with o_div_zero=0 when the divisor is nonzero.
- Reset asserted mid-CALC: immediately return to reset values. No o_done is produced for the aborted operation.
- o_quotient and o_remainder change only on the edge entering DONE or on reset.

Decomposition:
- Shared header/package holds:
  - state encodings S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2
  - default DIV_WIDTH=4
- One natural sub-module: div_step. It is a combinational single iteration with WIDTH-parameterised inputs Rs and D, and outputs r_next and q_bit, using the invert-and-add-one subtract with borrow from carry.
- Counter, FSM and registers live in seq_divider.

Test Plan:
- WIDTH=4, start with 13/4 → o_done 5 edges later; q=3, r=1, o_div_zero=0; o_busy high for exactly 4 cycles.
- 15/1 → q=15, r=0. Then 3/9 → q=0, r=3. Then 0/5 → q=0, r=0.
- 7/0 → o_done one edge after start; q=15, r=7, o_div_zero=1; o_busy never high.
- 12/5 started; i_start pulsed with 9/3 during CALC → ignored; result q=2, r=2. Next, i_start held high during the DONE cycle with 9/3 → accepted; q=3, r=0 five edges later.
- rst_n pulled low two cycles into CALC of 14/3 → outputs zero asynchronously, no o_done. After release, 14/3 → q=4, r=2.
- Exhaustive sweep of all 256 dividend/divisor pairs at WIDTH=4, checked against a reference model using / and %. Divisor 0 is checked against the div-by-zero rule.
